// File: rtl/result_writer_pkg.sv
// Shared types for the result writer: FSM state encoding, bus widths and the
// buffered request record.
package result_writer_pkg;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    GAP   = 2'b10
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/result_fifo.sv
// Request buffer for the result writer: power-of-two circular FIFO with
// an occupancy counter and a combinational head output.
module result_fifo
  import result_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t push_req,
  input  logic pop,
  output req_t head,
  output logic full,
  output logic empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/result_writer.sv
// Buffered memory write port: queues requests and issues them one at a time
// with a fixed idle gap. Optional write counter enabled by RESULT_WRITER_COUNT_EN.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              wen,
  input  logic              mem_stall,
  output logic              busy,
  output logic [7:0]        wr_count
);
  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             pop, full, empty;
  req_t             in_req, head;

  assign in_req.addr = push_addr;
  assign in_req.data = push_data;

  // Head stays queued until memory takes it, so a stalled write still
  // occupies a FIFO slot.
  assign pop        = (state == WRITE) && !mem_stall;
  assign push_ready = !full;
  assign busy       = !empty || (state != IDLE);

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_valid),
    .push_req (in_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wen     <= 1'b0;
      addr    <= '0;
      data    <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= WRITE;
            wen   <= 1'b1;
            addr  <= head.addr;
            data  <= head.data;
          end
        end
        WRITE: begin
          if (!mem_stall) begin
            state   <= GAP;
            wen     <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYCLES);
          end
        end
        GAP: begin
          if (gap_cnt > GAP_W'(1)) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            gap_cnt <= '0;
            if (!empty) begin
              state <= WRITE;
              wen   <= 1'b1;
              addr  <= head.addr;
              data  <= head.data;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          wen   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESULT_WRITER_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     wr_count <= '0;
    else if (pop) wr_count <= wr_count + 8'd1;
  end
`else
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: queue-based timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_result_writer;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
`ifdef RESULT_WRITER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        push_valid, push_ready;
  logic [29:0] push_addr, addr;
  logic [31:0] push_data, data;
  logic        wen, mem_stall, busy;
  logic [7:0]  wr_count;

  int total = 0;
  int bad   = 0;

  result_writer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_addr  (push_addr),
    .push_data  (push_data),
    .addr       (addr),
    .data       (data),
    .wen        (wen),
    .mem_stall  (mem_stall),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending requests in a queue; the write phase is described by
  // whether a write is being offered and how many gap cycles remain.
  logic [61:0] q[$];
  logic [61:0] wlog[$];
  bit          m_wen = 1'b0;
  int          gap_left = 0;
  int          acc = 0;
  logic [29:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          pre_sz;
  bit          do_push;
  int          wen_cycles = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_wen = 1'b0; gap_left = 0; acc = 0; m_addr = '0; m_data = '0;
      end else begin
        pre_sz  = q.size();
        do_push = push_valid && (pre_sz < DEPTH);
        if (m_wen) begin
          if (!mem_stall) begin
            q.delete(0);
            acc++;
            m_wen = 1'b0;
            gap_left = GAP;
          end
        end else if (gap_left > 1) begin
          gap_left--;
        end else begin
          gap_left = 0;
          if (pre_sz > 0) begin
            m_wen = 1'b1;
            {m_addr, m_data} = q[0];
          end
        end
        if (do_push) q.push_back({push_addr, push_data});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("wen", wen, m_wen);
        chk("addr", addr, m_addr);
        chk("data", data, m_data);
        chk("push_ready", push_ready, q.size() < DEPTH);
        chk("busy", busy, (q.size() > 0) || m_wen || (gap_left > 0));
        chk("wr_count", wr_count, CNT_EN ? (acc % 256) : 0);
        if (wen) wen_cycles++;
        if (wen && !mem_stall) wlog.push_back({addr, data});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [29:0] a, input logic [31:0] d, output int waited);
    bit ok;
    waited = 0;
    push_valid = 1'b1; push_addr = a; push_data = d;
    do begin
      ok = push_ready;
      tick(1);
      waited++;
    end while (!ok && waited < 200);
    push_valid = 1'b0;
    if (!ok) chk("push_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      tick(1);
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int w;
  logic [7:0] pat;
  int exp_d[4] = '{5, 4, 4, 4};

  initial begin
    rst = 1'b0; push_valid = 1'b0; push_addr = '0; push_data = '0; mem_stall = 1'b0;
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_ready", push_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", wr_count, 0);
    tick(2);
    rst = 1'b1;

    // single write, no stall
    wlog.delete(); wen_cycles = 0;
    push(30'd0, 32'd5, w);
    chk("first_push_edges", w, 1);
    chk("lat_wen0", wen, 0);
    tick(1);
    chk("lat_wen1", wen, 1);
    tick(1);
    chk("after_write_wen", wen, 0);
    wait_idle();
    chk("single_cycles", wen_cycles, 1);
    chk("single_n", wlog.size(), 1);
    chk("single_val", wlog[0], {30'd0, 32'd5});

    // stall for three cycles
    wlog.delete(); wen_cycles = 0;
    mem_stall = 1'b1;
    push(30'd7, 32'hAB, w);
    tick(4);
    mem_stall = 1'b0;
    wait_idle();
    chk("stall_cycles", wen_cycles, 4);
    chk("stall_n", wlog.size(), 1);
    chk("stall_val", wlog[0], {30'd7, 32'hAB});

    // fill to full while stalled, fifth held
    wlog.delete();
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(30'(i), 32'(100 + i), w);
    chk("full_ready", push_ready, 0);
    push_valid = 1'b1; push_addr = 30'd4; push_data = 32'd104;
    tick(3);
    chk("held_ready", push_ready, 0);
    mem_stall = 1'b0;
    push(30'd4, 32'd104, w);
    wait_idle();
    chk("order_n", wlog.size(), 5);
    for (int i = 0; i < 5; i++) chk("order_addr", wlog[i][61:32], 30'(i));

    // back-to-back drain pattern
    wlog.delete();
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(30'(20 + i), 32'(exp_d[i]), w);
    mem_stall = 1'b0;
    pat = {7'd0, wen};
    for (int i = 0; i < 7; i++) begin
      tick(1);
      pat = {pat[6:0], wen};
    end
    chk("wen_pattern", pat, 8'hAA);
    wait_idle();
    chk("drain_n", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("drain_data", wlog[i][31:0], 32'(exp_d[i]));

    // async reset mid-write with entries queued
    wlog.delete();
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(30'(30 + i), 32'(200 + i), w);
    tick(1);
    chk("pre_rst_wen", wen, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_wen", wen, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", push_ready, 1);
    tick(1);
    rst = 1'b1;
    mem_stall = 1'b0;
    tick(6);
    chk("post_rst_writes", wlog.size(), 0);
    chk("post_rst_wen", wen, 0);

    // counter wrap
    wlog.delete();
    for (int i = 0; i < 256; i++) push(30'(i), 32'(i * 3), w);
    wait_idle();
    chk("count_256", wr_count, 0);
    push(30'd256, 32'd768, w);
    wait_idle();
    chk("count_257", wr_count, CNT_EN ? 1 : 0);
    chk("count_writes", wlog.size(), 257);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
